// File: rtl/globals.sv
// Shared audio-path definitions: data widths, sample pacing defaults, the
// output sequencer state type and the sample saturation helper.
package globals;

    localparam int DATA_SIZE           = 32;
    localparam int AUDIO_OUT_SIZE      = 16;
    localparam int AUDIO_SAMPLE_PERIOD = 8;

    // Saturation is carried out at this width so any DATA_SIZE up to 64 fits.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        SEND_L    = 2'd2,
        SEND_R    = 2'd3
    } audio_seq_state_t;

    // Clamp a sign-extended sample to the signed out_size range; the caller
    // keeps the low out_size bits of the result.
    function automatic logic [SAT_W-1:0] saturate_sample(
        input logic signed [SAT_W-1:0] v,
        input int                      out_size
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = $signed((64'd1 << (out_size - 1)) - 64'd1);
        min_v = -max_v - 64'sd1;
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// Enable-gated modulo counter; tick marks the last cycle of each sample period
// and the count is parked at zero while enable is low.
module audio_tick_gen
    import globals::*;
#(
    parameter int SAMPLE_PERIOD = AUDIO_SAMPLE_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = '0;
        if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/audio_out_sequencer.sv
// Paced stereo output: pops a left/right pair per sample tick, saturates it and
// emits left then right on a valid/ready stream. AUDIO_SEQ_HOLD_EN: underruns
// repeat the last popped pair instead of emitting zeros.
module audio_out_sequencer #(
    parameter int DATA_SIZE     = globals::DATA_SIZE,
    parameter int OUT_SIZE      = globals::AUDIO_OUT_SIZE,
    parameter int SAMPLE_PERIOD = globals::AUDIO_SAMPLE_PERIOD,
    parameter int CNT_SIZE      = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear_stats,
    input  logic                left_empty,
    input  logic                right_empty,
    input  logic [DATA_SIZE-1:0] left_dout,
    input  logic [DATA_SIZE-1:0] right_dout,
    output logic                left_rd_en,
    output logic                right_rd_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out_data,
    output logic                out_channel,
    output logic [CNT_SIZE-1:0] underrun_count,
    output logic                overrun,
    output logic                busy
);

    import globals::audio_seq_state_t;
    import globals::IDLE;
    import globals::WAIT_TICK;
    import globals::SEND_L;
    import globals::SEND_R;
    import globals::SAT_W;
    import globals::saturate_sample;

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; out_data/out_channel hold while out_ready is low.

    audio_seq_state_t    state_q;
    logic [DATA_SIZE-1:0] left_cap_q;
    logic [DATA_SIZE-1:0] right_cap_q;
    logic [DATA_SIZE-1:0] left_next;
    logic [DATA_SIZE-1:0] right_next;
    logic [OUT_SIZE-1:0]  out_data_q;
    logic                 out_valid_q;
    logic                 out_channel_q;
    logic                 busy_q;
    logic [CNT_SIZE-1:0]  underrun_q;
    logic [CNT_SIZE-1:0]  underrun_d;
    logic                 overrun_q;
    logic                 overrun_d;
    logic                 tick;
    logic                 frame_start;
    logic                 pop;
    logic                 underrun_evt;
    logic                 late_tick;

    audio_tick_gen #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    function automatic logic [OUT_SIZE-1:0] sat_out(input logic [DATA_SIZE-1:0] v);
        return OUT_SIZE'(saturate_sample({{(SAT_W - DATA_SIZE){v[DATA_SIZE-1]}}, v}, OUT_SIZE));
    endfunction

    assign frame_start  = (state_q == WAIT_TICK) && tick && enable;
    assign pop          = frame_start && !left_empty && !right_empty;
    assign underrun_evt = frame_start && (left_empty || right_empty);
    assign late_tick    = tick && ((state_q == SEND_L) || (state_q == SEND_R));

    // On underrun neither FIFO is touched, even the one that has data.
    always_comb begin
        left_next  = left_dout;
        right_next = right_dout;
        if (!pop) begin
`ifdef AUDIO_SEQ_HOLD_EN
            left_next  = left_cap_q;
            right_next = right_cap_q;
`else
            left_next  = '0;
            right_next = '0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            left_cap_q    <= '0;
            right_cap_q   <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_channel_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        left_cap_q    <= left_next;
                        right_cap_q   <= right_next;
                        out_data_q    <= sat_out(left_next);
                        out_valid_q   <= 1'b1;
                        out_channel_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= SEND_L;
                    end
                end
                SEND_L: begin
                    if (out_ready) begin
                        out_data_q    <= sat_out(right_cap_q);
                        out_channel_q <= 1'b1;
                        state_q       <= SEND_R;
                    end
                end
                SEND_R: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= WAIT_TICK;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        underrun_d = underrun_q;
        overrun_d  = overrun_q | late_tick;
        if (underrun_evt && (underrun_q != '1)) begin
            underrun_d = underrun_q + 1'b1;
        end
        if (clear_stats) begin
            underrun_d = '0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            underrun_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign left_rd_en     = pop;
    assign right_rd_en    = pop;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_channel    = out_channel_q;
    assign underrun_count = underrun_q;
    assign overrun        = overrun_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_audio_out_sequencer.sv
// Directed-then-random bench for audio_out_sequencer against a frame-level
// reference model with FIFO queues and an expected-word queue.
module tb_audio_out_sequencer;

  localparam int P  = 8;
  localparam int DW = 32;
  localparam int OW = 16;
  localparam int CW = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          enable = 1'b0;
  logic          clear_stats = 1'b0;
  logic          left_empty = 1'b1;
  logic          right_empty = 1'b1;
  logic [DW-1:0] left_dout = '0;
  logic [DW-1:0] right_dout = '0;
  logic          left_rd_en;
  logic          right_rd_en;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_channel;
  logic [CW-1:0] underrun_count;
  logic          overrun;
  logic          busy;

  audio_out_sequencer #(
    .DATA_SIZE(DW),
    .OUT_SIZE(OW),
    .SAMPLE_PERIOD(P),
    .CNT_SIZE(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .clear_stats(clear_stats),
    .left_empty(left_empty),
    .right_empty(right_empty),
    .left_dout(left_dout),
    .right_dout(right_dout),
    .left_rd_en(left_rd_en),
    .right_rd_en(right_rd_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_channel(out_channel),
    .underrun_count(underrun_count),
    .overrun(overrun),
    .busy(busy)
  );

  // environment FIFOs and reference model
  logic [DW-1:0] lq[$];
  logic [DW-1:0] rq[$];
  logic [OW:0]   exp_q[$];   // {channel, word}
  int            m_cnt;
  logic [CW-1:0] m_under;
  logic          m_over;
  logic [DW-1:0] last_l;
  logic [DW-1:0] last_r;

  logic en_v = 1'b0;
  logic rdy_v = 1'b0;
  logic clr_v = 1'b0;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] sat16(input logic [DW-1:0] v);
    longint s;
    s = longint'($signed(v));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic logic [DW-1:0] rand_sample();
    logic [15:0] h;
    logic [DW-1:0] b[6];
    b[0] = 32'h0000_7FFF; b[1] = 32'hFFFF_8000; b[2] = 32'h0000_8000;
    b[3] = 32'hFFFF_7FFF; b[4] = 32'h7FFF_FFFF; b[5] = 32'h8000_0000;
    h = 16'($urandom);
    case ($urandom_range(0, 3))
      0: return {{16{h[15]}}, h};
      1: return $urandom;
      2: return b[$urandom_range(0, 5)];
      default: return {{15{h[15]}}, h, 1'b1};
    endcase
  endfunction

  task automatic drive_fifos();
    left_empty  = (lq.size() == 0);
    right_empty = (rq.size() == 0);
    left_dout   = left_empty  ? 32'hDEAD_BEEF : lq[0];
    right_dout  = right_empty ? 32'hBEEF_DEAD : rq[0];
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt = 0;
    m_under = '0;
    m_over = 1'b0;
    last_l = '0;
    last_r = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_left_rd_en"}, left_rd_en, 0);
    check({tag, "_right_rd_en"}, right_rd_en, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_channel"}, out_channel, 0);
    check({tag, "_underrun_count"}, underrun_count, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    logic          tick;
    logic          busy_m;
    logic          exp_rd;
    logic          under;
    logic          pl;
    logic          pr;
    logic [OW:0]   e;
    logic [DW-1:0] fl;
    logic [DW-1:0] fr;
    enable = en_v;
    out_ready = rdy_v;
    clear_stats = clr_v;
    drive_fifos();
    #1;
    tick   = en_v && (m_cnt == P - 1);
    busy_m = (exp_q.size() != 0);
    exp_rd = tick && !busy_m && (lq.size() != 0) && (rq.size() != 0);
    check("left_rd_en", left_rd_en, exp_rd);
    check("right_rd_en", right_rd_en, exp_rd);
    check("out_valid", out_valid, busy_m);
    check("busy", busy, busy_m);
    if (busy_m) begin
      e = exp_q[0];
      check("out_data", out_data, e[OW-1:0]);
      check("out_channel", out_channel, e[OW]);
    end
    check("underrun_count", underrun_count, m_under);
    check("overrun", overrun, m_over);
    pl = left_rd_en;
    pr = right_rd_en;
    under = 1'b0;
    if (busy_m && rdy_v) exp_q.pop_front();
    if (tick && !busy_m) begin
      if (lq.size() != 0 && rq.size() != 0) begin
        fl = lq[0];
        fr = rq[0];
        last_l = fl;
        last_r = fr;
      end else begin
        under = 1'b1;
`ifdef AUDIO_SEQ_HOLD_EN
        fl = last_l;
        fr = last_r;
`else
        fl = '0;
        fr = '0;
`endif
      end
      exp_q.push_back({1'b0, sat16(fl)});
      exp_q.push_back({1'b1, sat16(fr)});
    end
    if (clr_v) begin
      m_under = '0;
      m_over = 1'b0;
    end else begin
      if (under && m_under != '1) m_under = m_under + 1'b1;
      if (tick && busy_m) m_over = 1'b1;
    end
    m_cnt = en_v ? ((m_cnt == P - 1) ? 0 : m_cnt + 1) : 0;
    if (pl && lq.size() != 0) void'(lq.pop_front());
    if (pr && rq.size() != 0) void'(rq.pop_front());
    @(posedge clock);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model holds `words` pending words (2 = left on the bus, 1 = right).
  task automatic wait_words(input string tag, input int words, input int limit);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == words) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check(tag, hit, 1);
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    lq.push_back(l);
    rq.push_back(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    drive_fifos();
    repeat (2) @(posedge clock);
    #2;
    check_reset_values("por");
    reset = 1'b1;

    // nominal frame, second frame one period later
    push_pair(32'h0000_1234, 32'hFFFF_FF00);
    push_pair(32'h0000_0001, 32'h0000_0002);
    en_v = 1'b1;
    rdy_v = 1'b1;
    run(24);

    // saturation both directions
    push_pair(32'h0001_2345, 32'hFFFE_0000);
    run(10);

    // underrun with only the left FIFO holding data
    clr_v = 1'b1;
    step();
    clr_v = 1'b0;
    lq.delete();
    rq.delete();
    lq.push_back(32'h0000_5555);
    run(12);
    check("underrun_left_depth", lq.size(), 1);
    lq.delete();

    // backpressure across a tick, then clear
    push_pair(32'h0000_0AAA, 32'h0000_0BBB);
    push_pair(32'h0000_0CCC, 32'h0000_0DDD);
    wait_words("reach_send_l_bp", 2, 20);
    rdy_v = 1'b0;
    run(12);
    check("overrun_after_stall", overrun, 1);
    rdy_v = 1'b1;
    clr_v = 1'b1;
    step();
    clr_v = 1'b0;
    step();
    check("overrun_cleared", overrun, 0);
    run(16);

    // enable drop during the left word
    lq.delete();
    rq.delete();
    for (int i = 0; i < 4; i++) push_pair(rand_sample(), rand_sample());
    wait_words("reach_send_l_en", 2, 20);
    en_v = 1'b0;
    run(20);
    check("no_pop_while_disabled", lq.size(), 3);
    en_v = 1'b1;
    run(20);

    // asynchronous reset while the right word is on the bus
    for (int i = 0; i < 3; i++) push_pair(rand_sample(), rand_sample());
    wait_words("reach_send_r", 1, 20);
    reset = 1'b0;
    #1;
    check_reset_values("async");
    model_clear();
    @(posedge clock);
    #2;
    reset = 1'b1;
    run(20);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en_v  = ($urandom_range(0, 49) != 0);
      rdy_v = ($urandom_range(0, 3) != 0);
      clr_v = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 3 && lq.size() < 4) lq.push_back(rand_sample());
      if ($urandom_range(0, 9) < 3 && rq.size() < 4) rq.push_back(rand_sample());
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
